// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, scanner state encodings and matrix lookup
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    // Layout: r0=1 2 3 A, r1=4 5 6 B, r2=7 8 9 C, r3=* 0 # D
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
        logic [1:0] idx;
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column scan, row synchroniser and press/release debounce FSM
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SLOTS = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int STABLE = DEBOUNCE_SLOTS * 4;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(STABLE + 1);

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic [1:0]       r_state;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_row_idx;
    logic [3:0]       r_row_pat;
    logic [CNT_W-1:0] r_cnt;

    logic             w_slot_end;
    logic             w_row_any;
    logic             w_match;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_slot_end = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_row_any  = (r_row_s2 != 4'hF);
    assign w_match    = (r_row_s2 == r_row_pat);
    assign w_cnt_next = r_cnt + 1'b1;
    assign Col        = ~(4'b0001 << r_col_idx);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_row_s1  <= 4'hF;
            r_row_s2  <= 4'hF;
            r_state   <= SCAN;
            r_col_idx <= 2'd0;
            r_row_idx <= 2'd0;
            r_row_pat <= 4'hF;
            r_cnt     <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= 1'b0;
            r_row_s1  <= Row;
            r_row_s2  <= r_row_s1;
            r_div     <= w_slot_end ? '0 : r_div + 1'b1;

            if (w_slot_end) begin
                case (r_state)
                    SCAN: begin
                        if (w_row_any) begin
                            // Freeze Col on this column; the latching sample itself is not counted
                            r_row_pat <= r_row_s2;
                            r_row_idx <= lowest_low_row(r_row_s2);
                            r_cnt     <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_col_idx <= r_col_idx + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!w_match) begin
                            r_cnt   <= '0;
                            r_state <= SCAN;
                        end else if (w_cnt_next == CNT_W'(STABLE)) begin
                            r_cnt     <= '0;
                            key_valid <= 1'b1;
                            key_code  <= key_lookup(r_row_idx, r_col_idx);
                            r_state   <= HELD;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    HELD: begin
                        if (w_row_any) begin
                            r_cnt <= '0;
                        end else if (w_cnt_next == CNT_W'(STABLE)) begin
                            r_cnt   <= '0;
                            r_state <= SCAN;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_bcd_entry.sv
// rtl/keypad_bcd_entry.sv - keypad two-digit BCD entry converted to a range-checked binary preset
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SLOTS = 4,
    parameter int MAX_VALUE      = 59,
    parameter int VALUE_W        = 6
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [3:0]         Row,
    output logic [3:0]         Col,
    output logic               key_valid,
    output logic [3:0]         key_code,
    output logic [3:0]         digit_tens,
    output logic [3:0]         digit_units,
    output logic [VALUE_W-1:0] value_bin,
    output logic               value_valid,
    output logic               entry_err
);

    logic [1:0] r_count;
    logic [6:0] w_tens_ext;
    logic [6:0] w_sum;
    logic       w_is_digit;
    logic       w_in_range;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SLOTS (DEBOUNCE_SLOTS)
    ) u_scanner (
        .clk_in    (clk_in),
        .reset     (reset),
        .Row       (Row),
        .Col       (Col),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // tens*10 as shift-add so no multiplier is inferred
    assign w_tens_ext = {3'b000, digit_tens};
    assign w_sum      = (w_tens_ext << 3) + (w_tens_ext << 1) + {3'b000, digit_units};
    assign w_is_digit = (key_code <= 4'd9);
    assign w_in_range = (r_count != 2'd0) && (w_sum <= 7'(MAX_VALUE));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            digit_tens  <= 4'd0;
            digit_units <= 4'd0;
            r_count     <= 2'd0;
            value_bin   <= '0;
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
            if (key_valid) begin
                if (w_is_digit) begin
                    digit_tens  <= digit_units;
                    digit_units <= key_code;
                    r_count     <= (r_count == 2'd2) ? 2'd2 : r_count + 1'b1;
                end else if (key_code == KEY_STAR) begin
                    digit_tens  <= 4'd0;
                    digit_units <= 4'd0;
                    r_count     <= 2'd0;
                end else if (key_code == KEY_HASH) begin
                    if (w_in_range) begin
                        value_bin   <= w_sum[VALUE_W-1:0];
                        value_valid <= 1'b1;
                    end else begin
                        entry_err <= 1'b1;
                    end
                    digit_tens  <= 4'd0;
                    digit_units <= 4'd0;
                    r_count     <= 2'd0;
                end
            end
        end
    end

endmodule
